input_port_buffer: RTL and testbench



---
 rtl/input_port_buffer.sv | 132 +++++++++++++
 tb/tb_input_port_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_buffer.sv
// input_port_buffer: per-port router input stage.
// Buffers incoming flits in a small circular FIFO and decodes the header at the
// FIFO head. It then requests the downstream output arbiter and, while granted,
// forwards the packet flit by flit to the crossbar.
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   in_flit/valid    upstream flit; in_ready = FIFO not full
//   flit_id, length  id of the head flit (000 when empty); length of the last header
//   req, grant       arbiter request, and this port's grant bit from the arbiter
//   out_flit/valid   head flit to the crossbar; out_ready is the downstream accept
//   drop             asserted in a cycle whose orphan head flit is being discarded
module input_port_buffer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_flit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [2:0]        flit_id,
   output logic [11:0]       length,
   output logic              req,
   input  logic              grant,
   output logic [DATA_W-1:0] out_flit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              drop
);

   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam logic [2:0]  ID_HEAD = 3'b001;
   localparam logic [2:0]  ID_TAIL = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   state_t            state_q;
   logic [11:0]       length_q;

   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              orphan;
   logic              head_is_hdr;
   logic              head_is_tail;
   logic [DATA_W-1:0] head_flit;

   // Head view: an empty FIFO reads as all zeros, so flushed entries never leak out.
   assign empty        = (count_q == '0);
   assign full         = (count_q == CNT_W'(DEPTH));
   assign head_flit    = empty ? '0 : mem_q[rd_ptr_q];
   assign flit_id      = head_flit[DATA_W-1 -: 3];
   assign head_is_hdr  = !empty && (flit_id == ID_HEAD);
   assign head_is_tail = !empty && (flit_id == ID_TAIL);

   // Non-header flit at the head while no packet is open: it has no route, so discard it.
   assign orphan    = (state_q == ST_IDLE) && !empty && !head_is_hdr;
   assign out_valid = (state_q == ST_SEND) && grant && !empty;
   assign push      = in_valid && !full;
   assign pop       = (out_valid && out_ready) || orphan;

   assign in_ready  = !full;
   assign req       = (state_q != ST_IDLE);
   assign length    = length_q;
   assign out_flit  = head_flit;
   assign drop      = orphan;

   // Pointer and occupancy update; a push and a pop in the same cycle leave the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the occupancy count decides what is visible.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_flit;
   end

   // Packet control: announce a header, wait for a grant, forward until the tail leaves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         length_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (head_is_hdr) begin
                  state_q  <= ST_REQ;
                  length_q <= head_flit[11:0];
               end
            end
            ST_REQ: begin
               if (grant) state_q <= ST_SEND;
            end
            ST_SEND: begin
               // Losing the grant mid-packet keeps the remaining flits queued for the regrant.
               if (pop && head_is_tail) state_q <= ST_IDLE;
               else if (!grant)         state_q <= ST_REQ;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_input_port_buffer.sv
module tb_input_port_buffer;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] in_flit = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        flit_id;
   logic [11:0]       length;
   logic              req;
   logic              grant = 1'b0;
   logic [DATA_W-1:0] out_flit;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              drop;

   int n_vec = 0;
   int n_err = 0;

   input_port_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
      .flit_id(flit_id), .length(length), .req(req), .grant(grant),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
      .drop(drop)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [2:0] id, input logic [28:0] pl);
      return {id, pl};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; in_flit = '0; grant = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_vec++; if (req !== 1'b0)       begin n_err++; $display("FAIL reset_req got %b want 0", req); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++; if (drop !== 1'b0)      begin n_err++; $display("FAIL reset_drop got %b want 0", drop); end
      n_vec++; if (flit_id !== 3'b000) begin n_err++; $display("FAIL reset_flit_id got %b want 000", flit_id); end
      n_vec++; if (out_flit !== 32'h0) begin n_err++; $display("FAIL reset_out_flit got %h want 0", out_flit); end
      n_vec++; if (length !== 12'h0)   begin n_err++; $display("FAIL reset_length got %h want 0", length); end
      do_reset();
      // Bring a packet into forwarding, then hit reset between clock edges.
      grant = 1'b1; out_ready = 1'b0;
      in_valid = 1'b1; in_flit = mk(3'b001, {17'h00042, 12'h0AB});
      tick();
      in_flit = mk(3'b010, 29'h0DEAD01);
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_out_valid got %b want 1", out_valid); end
      n_vec++; if (length !== 12'h0AB) begin n_err++; $display("FAIL pre_reset_length got %h want 0ab", length); end
      #1;
      rst = 1'b0;
      #1;
      n_vec++; if (req !== 1'b0)       begin n_err++; $display("FAIL midreset_req got %b want 0", req); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
      n_vec++; if (flit_id !== 3'b000) begin n_err++; $display("FAIL midreset_flit_id got %b want 000", flit_id); end
      n_vec++; if (out_flit !== 32'h0) begin n_err++; $display("FAIL midreset_out_flit got %h want 0", out_flit); end
      n_vec++; if (length !== 12'h0)   begin n_err++; $display("FAIL midreset_length got %h want 0", length); end
      do_reset();
   endtask

   task automatic test_single_packet();
      logic [31:0] f [3];
      logic        req_prev;
      f[0] = mk(3'b001, {17'h01234, 12'h005});
      f[1] = mk(3'b010, 29'h0ABCDEF);
      f[2] = mk(3'b100, 29'h1234567);
      do_reset();
      out_ready = 1'b1;
      req_prev = 1'b0;
      for (int c = 0; c < 9; c++) begin
         grant    = req_prev;
         in_valid = (c < 3);
         in_flit  = f[(c < 3) ? c : 2];
         @(negedge clk);
         req_prev = req;
         case (c)
            1: begin
               n_vec++; if (flit_id !== 3'b001) begin n_err++; $display("FAIL sp_head_id got %b want 001", flit_id); end
               n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL sp_req_c1 got %b want 0", req); end
            end
            2: begin
               n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL sp_req_c2 got %b want 1", req); end
               n_vec++; if (length !== 12'h005) begin n_err++; $display("FAIL sp_length got %h want 005", length); end
            end
            3: begin
               n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sp_ov_c3 got %b want 0", out_valid); end
            end
            4, 5, 6: begin
               n_vec++; if (out_valid !== 1'b1 || out_flit !== f[c-4]) begin
                  n_err++; $display("FAIL sp_flit%0d got v=%b %h want v=1 %h", c-4, out_valid, out_flit, f[c-4]);
               end
            end
            7: begin
               n_vec++; if (req !== 1'b0 || out_valid !== 1'b0) begin
                  n_err++; $display("FAIL sp_after_tail got req=%b ov=%b want 0 0", req, out_valid);
               end
            end
            default: ;
         endcase
         tick();
      end
   endtask

   task automatic test_fill();
      logic [31:0] f [5];
      logic [31:0] got [$];
      f[0] = mk(3'b001, {17'h00001, 12'h003});
      f[1] = mk(3'b010, 29'h0000111);
      f[2] = mk(3'b010, 29'h0000222);
      f[3] = mk(3'b100, 29'h0000333);
      f[4] = mk(3'b001, {17'h00002, 12'h0FF});
      do_reset();
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_flit = f[c];
         @(negedge clk);
         n_vec++; if (in_ready !== (c < 4)) begin n_err++; $display("FAIL fill_in_ready_%0d got %b want %b", c, in_ready, (c < 4)); end
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b0 || flit_id !== 3'b001 || req !== 1'b1) begin
         n_err++; $display("FAIL fill_full_state got rdy=%b id=%b req=%b want 0 001 1", in_ready, flit_id, req);
      end
      tick();
      grant = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) got.push_back(out_flit);
         if (c == 2) begin
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_restored got %b want 1", in_ready); end
         end
         tick();
      end
      n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL fill_drain_count got %0d want 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_vec++; if (got[i] !== f[i]) begin n_err++; $display("FAIL fill_drain_%0d got %h want %h", i, got[i], f[i]); end
      end
      n_vec++; if (flit_id !== 3'b000 || req !== 1'b0) begin
         n_err++; $display("FAIL fill_empty_end got id=%b req=%b want 000 0", flit_id, req);
      end
   endtask

   task automatic test_grant_withdraw();
      logic [31:0] f [4];
      logic [31:0] got [$];
      f[0] = mk(3'b001, {17'h00005, 12'h004});
      f[1] = mk(3'b010, 29'h00000B1);
      f[2] = mk(3'b010, 29'h00000B2);
      f[3] = mk(3'b100, 29'h00000F0);
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (c < 4);
         in_flit  = f[(c < 4) ? c : 3];
         grant    = !(c == 5 || c == 6);
         @(negedge clk);
         if (out_valid && out_ready) got.push_back(out_flit);
         if (c == 5) begin
            n_vec++; if (out_valid !== 1'b0 || req !== 1'b1) begin
               n_err++; $display("FAIL gw_drop_same_cycle got ov=%b req=%b want 0 1", out_valid, req);
            end
         end
         if (c == 6) begin
            n_vec++; if (flit_id !== 3'b010 || req !== 1'b1) begin
               n_err++; $display("FAIL gw_waiting got id=%b req=%b want 010 1", flit_id, req);
            end
         end
         if (c == 7) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gw_regrant_req_state got ov=%b want 0", out_valid); end
         end
         tick();
      end
      n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL gw_count got %0d want 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_vec++; if (got[i] !== f[i]) begin n_err++; $display("FAIL gw_flit_%0d got %h want %h", i, got[i], f[i]); end
      end
   endtask

   task automatic test_orphan();
      logic [31:0] o, h;
      o = mk(3'b010, 29'h0000155);
      h = mk(3'b001, {17'h00000, 12'h7A1});
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_valid = (c < 2);
         in_flit  = (c == 0) ? o : h;
         @(negedge clk);
         case (c)
            1: begin
               n_vec++; if (drop !== 1'b1 || flit_id !== 3'b010) begin
                  n_err++; $display("FAIL orph_drop got drop=%b id=%b want 1 010", drop, flit_id);
               end
            end
            2: begin
               n_vec++; if (drop !== 1'b0 || flit_id !== 3'b001 || req !== 1'b0) begin
                  n_err++; $display("FAIL orph_after got drop=%b id=%b req=%b want 0 001 0", drop, flit_id, req);
               end
            end
            3: begin
               n_vec++; if (req !== 1'b1 || length !== 12'h7A1) begin
                  n_err++; $display("FAIL orph_hdr_req got req=%b len=%h want 1 7a1", req, length);
               end
            end
            default: ;
         endcase
         tick();
      end
   endtask

   // Random packet stream against a packet-level model: queue contents plus
   // "packet announced" and "forwarding under grant" flags.
   task automatic test_back_to_back();
      logic [31:0] src [$];
      logic [31:0] q [$];
      logic [31:0] e_head;
      logic [50:0] exp_v, got_v;
      logic        act, fwd, e_ov, e_drop, e_rdy, popped;
      logic [11:0] len_m;
      logic [2:0]  oid;
      int          idx, n_good, n_out, cyc;
      n_good = 0;
      for (int p = 0; p < 14; p++) begin
         if ($urandom_range(0, 3) == 0) begin
            oid = 3'($urandom);
            if (oid == 3'b001) oid = 3'b010;
            src.push_back(mk(oid, 29'($urandom)));
         end
         src.push_back(mk(3'b001, {17'($urandom), 12'($urandom)}));
         n_good++;
         for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
            src.push_back(mk(3'b010, 29'($urandom)));
            n_good++;
         end
         src.push_back(mk(3'b100, 29'($urandom)));
         n_good++;
      end
      do_reset();
      act = 1'b0; fwd = 1'b0; len_m = '0; idx = 0; n_out = 0; cyc = 0;
      while (cyc < 3000 && !(idx == src.size() && q.size() == 0 && !act)) begin
         in_valid  = (idx < src.size()) && ($urandom_range(0, 9) < 7);
         in_flit   = in_valid ? src[idx] : 32'($urandom);
         grant     = act && ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         e_head = (q.size() > 0) ? q[0] : 32'h0;
         e_rdy  = (q.size() < DEPTH);
         e_ov   = fwd && grant && (q.size() > 0);
         e_drop = !act && (q.size() > 0) && (e_head[31:29] != 3'b001);
         exp_v  = {e_rdy, e_head[31:29], act, e_ov, e_drop, len_m, e_head};
         got_v  = {in_ready, flit_id, req, out_valid, drop, length, out_flit};
         n_vec++; if (got_v !== exp_v) begin
            n_err++; $display("FAIL b2b_cycle%0d got %h want %h", cyc, got_v, exp_v);
         end
         popped = (e_ov && out_ready) || e_drop;
         if (e_ov && out_ready) n_out++;
         if (!act) begin
            if (q.size() > 0 && e_head[31:29] == 3'b001) begin act = 1'b1; len_m = e_head[11:0]; end
         end else if (!fwd) begin
            if (grant) fwd = 1'b1;
         end else if (popped && e_head[31:29] == 3'b100) begin
            act = 1'b0; fwd = 1'b0;
         end else if (!grant) begin
            fwd = 1'b0;
         end
         if (popped) void'(q.pop_front());
         if (in_valid && e_rdy) begin q.push_back(in_flit); idx++; end
         tick();
         cyc++;
      end
      n_vec++; if (cyc >= 3000) begin n_err++; $display("FAIL b2b_timeout got idx=%0d want %0d", idx, src.size()); end
      n_vec++; if (n_out != n_good) begin n_err++; $display("FAIL b2b_delivered got %0d want %0d", n_out, n_good); end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_fill();
      test_grant_withdraw();
      test_orphan();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
